// File: rtl/execute_alu_imm_pipe_pkg.sv
// Shared mode codes, select width and occupancy states for the execute-stage immediate pipe.
package execute_alu_imm_pipe_pkg;

  localparam int SEL_WIDTH = 3;

  typedef enum logic [SEL_WIDTH-1:0] {
    ALU_IMM_BYPASS = 3'd0,
    ALU_IMM_ZEXT   = 3'd1,
    ALU_IMM_SEXT   = 3'd2,
    ALU_IMM_LUI    = 3'd3,
    ALU_IMM_BOFS   = 3'd4,
    ALU_IMM_ZERO   = 3'd5
  } alu_imm_sel_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/execute_alu_imm_pipe_if.sv
// Operation-in / result-out handshake bundle; master drives operations and result ready.
interface execute_alu_imm_pipe_if
  import execute_alu_imm_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16,
  parameter int TAG_WIDTH  = 6
);

  logic                  i_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_d0;
  logic [IMM_WIDTH-1:0]  i_d1;
  logic [SEL_WIDTH-1:0]  i_sel;
  logic [TAG_WIDTH-1:0]  i_tag;
  logic                  o_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_s0;
  logic [TAG_WIDTH-1:0]  o_tag;

  modport master (
    output i_valid, i_d0, i_d1, i_sel, i_tag, o_ready,
    input  i_ready, o_valid, o_s0, o_tag
  );

  modport slave (
    input  i_valid, i_d0, i_d1, i_sel, i_tag, o_ready,
    output i_ready, o_valid, o_s0, o_tag
  );

endinterface

// File: rtl/execute_alu_imm_ext.sv
// Combinational operand selector: register bypass or immediate through zero/sign/LUI/branch-offset extension.
module execute_alu_imm_ext
  import execute_alu_imm_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16,
  parameter int LUI_SHIFT  = 16
) (
  input  logic [DATA_WIDTH-1:0] d0,
  input  logic [IMM_WIDTH-1:0]  d1,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0] zext;
  logic [DATA_WIDTH-1:0] sext;

  always_comb begin
    zext = '0;
    zext[IMM_WIDTH-1:0] = d1;
    sext = {{(DATA_WIDTH-IMM_WIDTH){d1[IMM_WIDTH-1]}}, d1};
    result = '0;
    // LUI and BOFS shift the sign-extended value so upper bits follow the immediate sign.
    case (alu_imm_sel_e'(sel))
      ALU_IMM_BYPASS: result = d0;
      ALU_IMM_ZEXT:   result = zext;
      ALU_IMM_SEXT:   result = sext;
      ALU_IMM_LUI:    result = sext << LUI_SHIFT;
      ALU_IMM_BOFS:   result = sext << 2;
      default:        result = '0;
    endcase
  end

endmodule

// File: rtl/execute_alu_imm_pipe.sv
// Registered immediate/operand selector with a one-entry skid buffer; 1-cycle latency, full throughput,
// i_ready driven from state only.
module execute_alu_imm_pipe
  import execute_alu_imm_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16,
  parameter int LUI_SHIFT  = 16,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  execute_alu_imm_pipe_if.slave  bus
);

  occ_state_e            state;
  logic                  ready_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] main_s0;
  logic [TAG_WIDTH-1:0]  main_tag;
  logic [DATA_WIDTH-1:0] skid_s0;
  logic [TAG_WIDTH-1:0]  skid_tag;
  logic [DATA_WIDTH-1:0] ext_s0;
  logic                  in_fire;
  logic                  out_fire;

  execute_alu_imm_ext #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH),
    .LUI_SHIFT  (LUI_SHIFT)
  ) u_ext (
    .d0     (bus.i_d0),
    .d1     (bus.i_d1),
    .sel    (bus.i_sel),
    .result (ext_s0)
  );

  assign in_fire  = bus.i_valid && ready_q;
  assign out_fire = valid_q && bus.o_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      main_s0  <= '0;
      main_tag <= '0;
      skid_s0  <= '0;
      skid_tag <= '0;
    end else if (flush) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_s0  <= ext_s0;
            main_tag <= bus.i_tag;
            valid_q  <= 1'b1;
            state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_s0  <= ext_s0;
            main_tag <= bus.i_tag;
          end else if (out_fire) begin
            valid_q <= 1'b0;
            state   <= ST_EMPTY;
          end else if (in_fire) begin
            skid_s0  <= ext_s0;
            skid_tag <= bus.i_tag;
            ready_q  <= 1'b0;
            state    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_s0  <= skid_s0;
            main_tag <= skid_tag;
            ready_q  <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          state   <= ST_EMPTY;
        end
      endcase
    end
  end

  assign bus.i_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_s0    = main_s0;
  assign bus.o_tag   = main_tag;

endmodule

// File: tb/tb_execute_alu_imm_pipe.sv
// Directed bench: a queue model of the accepted-but-unconsumed results checked every cycle, plus literal expectations.
module tb_execute_alu_imm_pipe;
  import execute_alu_imm_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic no_flush = 1'b0;
  logic armed = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  execute_alu_imm_pipe_if #(.DATA_WIDTH(32), .IMM_WIDTH(16), .TAG_WIDTH(6)) a ();
  execute_alu_imm_pipe_if #(.DATA_WIDTH(64), .IMM_WIDTH(16), .TAG_WIDTH(6)) b ();

  execute_alu_imm_pipe #(.DATA_WIDTH(32), .IMM_WIDTH(16), .LUI_SHIFT(16), .TAG_WIDTH(6)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .bus(a.slave));
  execute_alu_imm_pipe #(.DATA_WIDTH(64), .IMM_WIDTH(16), .LUI_SHIFT(16), .TAG_WIDTH(6)) dut64 (
    .clk(clk), .reset(reset), .flush(no_flush), .bus(b.slave));

  typedef struct {
    logic [31:0] s0;
    logic [5:0]  tag;
  } exp_t;

  exp_t        q[$];
  logic [5:0]  got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference extension in plain signed arithmetic.
  function automatic logic [31:0] ref_ext(input logic [31:0] d0, input logic [15:0] d1, input logic [2:0] sel);
    longint s;
    longint t;
    s = longint'($signed(d1));
    case (sel)
      3'd0: t = longint'(d0);
      3'd1: t = longint'(d1);
      3'd2: t = s;
      3'd3: t = s * 65536;
      3'd4: t = s * 4;
      default: t = 0;
    endcase
    return t[31:0];
  endfunction

  always @(posedge clk) begin
    automatic int n;
    if (reset) q.delete();
    else if (armed) begin
      n = q.size();
      if (n > 0 && a.o_ready) begin
        got.push_back(a.o_tag);
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (a.i_valid && n < 2) q.push_back('{ref_ext(a.i_d0, a.i_d1, a.i_sel), a.i_tag});
    end
  end

  always @(negedge clk) begin
    if (armed && !reset) begin
      chk("cmp_valid", a.o_valid, q.size() > 0);
      chk("cmp_ready", a.i_ready, q.size() < 2);
      if (q.size() > 0) begin
        chk("cmp_s0", a.o_s0, q[0].s0);
        chk("cmp_tag", a.o_tag, q[0].tag);
      end
    end
  end

  task automatic put_a(input logic [31:0] d0, input logic [15:0] d1, input logic [2:0] sel, input logic [5:0] tag);
    a.i_valid = 1'b1;
    a.i_d0 = d0;
    a.i_d1 = d1;
    a.i_sel = sel;
    a.i_tag = tag;
  endtask

  task automatic op_check(input logic [31:0] d0, input logic [15:0] d1, input logic [2:0] sel,
                          input logic [5:0] tag, input logic [31:0] exp, input string name);
    put_a(d0, d1, sel, tag);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, a.o_valid, 1'b1);
    chk(name, a.o_s0, exp);
    chk({name, "_tag"}, a.o_tag, tag);
  endtask

  task automatic op64_check(input logic [15:0] d1, input logic [63:0] exp, input string name);
    b.i_valid = 1'b1;
    b.i_d0 = 64'h0;
    b.i_d1 = d1;
    b.i_sel = ALU_IMM_LUI;
    b.i_tag = 6'd40;
    @(posedge clk);
    @(negedge clk);
    b.i_valid = 1'b0;
    chk({name, "_valid"}, b.o_valid, 1'b1);
    chk(name, b.o_s0, exp);
  endtask

  initial begin
    int cnt;
    a.i_valid = 1'b0; a.i_d0 = '0; a.i_d1 = '0; a.i_sel = '0; a.i_tag = '0; a.o_ready = 1'b1;
    b.i_valid = 1'b0; b.i_d0 = '0; b.i_d1 = '0; b.i_sel = '0; b.i_tag = '0; b.o_ready = 1'b1;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_valid", a.o_valid, 1'b0);
    chk("rst_ready", a.i_ready, 1'b1);
    chk("rst_s0", a.o_s0, 32'h0);
    chk("rst_tag", a.o_tag, 6'h0);
    #1 armed = 1'b1;

    @(negedge clk);
    op_check(32'h0, 16'h8001, ALU_IMM_SEXT, 6'd1, 32'hFFFF8001, "first_sext");
    op_check(32'hDEADBEEF, 16'h8123, 3'd0, 6'd2, 32'hDEADBEEF, "sw_bypass");
    op_check(32'hDEADBEEF, 16'h8123, 3'd1, 6'd3, 32'h00008123, "sw_zext");
    op_check(32'hDEADBEEF, 16'h8123, 3'd2, 6'd4, 32'hFFFF8123, "sw_sext");
    op_check(32'hDEADBEEF, 16'h8123, 3'd3, 6'd5, 32'h81230000, "sw_lui");
    op_check(32'hDEADBEEF, 16'h8123, 3'd4, 6'd6, 32'hFFFE048C, "sw_bofs");
    op_check(32'hDEADBEEF, 16'h8123, 3'd5, 6'd7, 32'h0, "sw_zero");
    op_check(32'hDEADBEEF, 16'h8123, 3'd6, 6'd8, 32'h0, "sw_rsv6");
    op_check(32'hDEADBEEF, 16'h8123, 3'd7, 6'd9, 32'h0, "sw_rsv7");
    a.i_valid = 1'b0;
    @(negedge clk);

    // Back-pressure: three ops against a stalled consumer.
    got.delete();
    a.o_ready = 1'b0;
    put_a(32'h0, 16'h0010, ALU_IMM_ZEXT, 6'd10);
    @(negedge clk);
    put_a(32'h0, 16'h0011, ALU_IMM_ZEXT, 6'd11);
    @(negedge clk);
    chk("bp_ready_low", a.i_ready, 1'b0);
    put_a(32'h0, 16'h0012, ALU_IMM_ZEXT, 6'd12);
    @(negedge clk);
    chk("bp_held_off", a.i_ready, 1'b0);
    chk("bp_head_stable", a.o_tag, 6'd10);
    a.o_ready = 1'b1;
    @(negedge clk);
    chk("bp_second", a.o_tag, 6'd11);
    @(negedge clk);
    a.i_valid = 1'b0;
    chk("bp_third", a.o_tag, 6'd12);
    @(negedge clk);
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_order0", got[0], 6'd10);
      chk("bp_order1", got[1], 6'd11);
      chk("bp_order2", got[2], 6'd12);
    end

    // Flush while full with a third op presented.
    got.delete();
    a.o_ready = 1'b0;
    put_a(32'h0, 16'h0020, ALU_IMM_ZEXT, 6'd20);
    @(negedge clk);
    put_a(32'h0, 16'h0021, ALU_IMM_ZEXT, 6'd21);
    @(negedge clk);
    put_a(32'h0, 16'h0022, ALU_IMM_ZEXT, 6'd22);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    a.i_valid = 1'b0;
    chk("flush_valid", a.o_valid, 1'b0);
    chk("flush_ready", a.i_ready, 1'b1);
    a.o_ready = 1'b1;
    repeat (4) @(negedge clk);
    cnt = 0;
    foreach (got[i]) if (got[i] >= 6'd20 && got[i] <= 6'd22) cnt++;
    chk("flush_dropped", cnt, 0);

    // Reset while holding one result against a stalled consumer.
    a.o_ready = 1'b0;
    put_a(32'h0, 16'h1234, ALU_IMM_ZEXT, 6'd30);
    @(negedge clk);
    a.i_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", a.o_valid, 1'b0);
    chk("mid_rst_s0", a.o_s0, 32'h0);
    chk("mid_rst_tag", a.o_tag, 6'h0);
    a.o_ready = 1'b1;
    @(negedge clk);
    op_check(32'h0, 16'h8001, ALU_IMM_SEXT, 6'd31, 32'hFFFF8001, "post_rst_sext");
    a.i_valid = 1'b0;

    op64_check(16'h8000, 64'hFFFFFFFF80000000, "w64_lui_neg");
    op64_check(16'h7FFF, 64'h000000007FFF0000, "w64_lui_pos");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
